// File: rtl/fht_stream_io.sv
// Streaming I/O wrapper for the FHT core: scatters input samples over the core RAM banks,
// starts the core, waits for its done edge, then gathers and streams the results in natural order.
module fht_stream_io #(
  parameter int N_PT      = 1024,
  parameter int N_BANK    = 4,
  parameter int A_BIT     = 8,
  parameter int IN_BIT    = 15,
  parameter int D_BIT     = 16,
  parameter int SIGNED_IN = 1,
  parameter int RD_LAT    = 1,
  parameter int CONT      = 0
) (
  input  logic                      iCLK,
  input  logic                      iRESET,
  input  logic                      iS_VALID,
  input  logic [IN_BIT-1:0]         iS_DATA,
  output logic                      oS_READY,
  output logic                      oM_VALID,
  output logic [D_BIT-1:0]          oM_DATA,
  output logic                      oM_LAST,
  input  logic                      iM_READY,
  output logic [N_BANK-1:0]         oCORE_WE,
  output logic [D_BIT-2:0]          oCORE_DATA,
  output logic [A_BIT-1:0]          oCORE_ADDR_WR,
  output logic [N_BANK*A_BIT-1:0]   oCORE_ADDR_RD,
  input  logic [N_BANK*D_BIT-1:0]   iCORE_DATA,
  output logic                      oCORE_START,
  input  logic                      iCORE_RDY,
  output logic                      oBUSY
);

  localparam int B_BIT = $clog2(N_BANK);
  localparam int C_BIT = $clog2(N_PT);
  localparam int W1    = D_BIT - 1;
  localparam logic [1:0] LAT = 2'(RD_LAT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_UNLOAD = 3'd4;

  // Offset-binary input is made two's complement by flipping the MSB, then sign-extended.
  function automatic logic [W1-1:0] conv(input logic [IN_BIT-1:0] s);
    logic signed [IN_BIT-1:0] t;
    t = s;
    if (SIGNED_IN == 0) t[IN_BIT-1] = ~s[IN_BIT-1];
    return W1'(t);
  endfunction

  logic [2:0]               state_q, state_d;
  logic                     rdy_q;
  logic [C_BIT-1:0]         cnt_q;
  logic [N_BANK-1:0]        we_q;
  logic [W1-1:0]            wdat_q;
  logic [A_BIT-1:0]         waddr_q;
  logic                     guard_q, prev_q;
  logic [A_BIT-1:0]         raddr_q;
  logic [1:0]               age_q;
  logic                     rdone_q;
  logic [N_BANK*D_BIT-1:0]  gath_q;
  logic                     gvld_q;
  logic [B_BIT-1:0]         bsel_q;
  logic [C_BIT-1:0]         ocnt_q;

  logic acc, beat, glast, olast, cap, rise;

  assign acc   = iS_VALID & rdy_q;
  assign beat  = gvld_q & iM_READY;
  assign glast = beat && (bsel_q == B_BIT'(N_BANK - 1));
  assign olast = beat && (ocnt_q == C_BIT'(N_PT - 1));
  assign rise  = guard_q & iCORE_RDY & ~prev_q;
  // A new bank row is captured only once its address has been stable for RD_LAT cycles
  // and the gather register is empty or handing over its last word this cycle.
  assign cap   = (state_q == S_UNLOAD) && !rdone_q && (age_q == LAT) && (!gvld_q || glast);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (acc) state_d = S_LOAD;
      S_LOAD:   if (acc && cnt_q == C_BIT'(N_PT - 1)) state_d = S_START;
      S_START:  state_d = S_RUN;
      S_RUN:    if (rise) state_d = S_UNLOAD;
      S_UNLOAD: if (olast) state_d = (CONT != 0) ? S_LOAD : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
      we_q    <= '0;
      wdat_q  <= '0;
      waddr_q <= '0;
      guard_q <= 1'b0;
      prev_q  <= 1'b0;
      raddr_q <= '0;
      age_q   <= '0;
      rdone_q <= 1'b0;
      gath_q  <= '0;
      gvld_q  <= 1'b0;
      bsel_q  <= '0;
      ocnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == S_IDLE) || (state_d == S_LOAD);
      we_q    <= '0;
      if (acc) begin
        cnt_q   <= cnt_q + 1'b1;
        we_q    <= N_BANK'(1) << cnt_q[B_BIT-1:0];
        waddr_q <= cnt_q[B_BIT +: A_BIT];
        wdat_q  <= conv(iS_DATA);
      end
      // The done edge only counts from the second cycle after the start strobe.
      prev_q  <= iCORE_RDY;
      guard_q <= (state_q == S_RUN);
      if (state_q == S_UNLOAD) begin
        if (cap) begin
          raddr_q <= raddr_q + 1'b1;
          age_q   <= '0;
          if (raddr_q == {A_BIT{1'b1}}) rdone_q <= 1'b1;
        end else if (age_q != LAT) begin
          age_q <= age_q + 1'b1;
        end
      end else begin
        raddr_q <= '0;
        age_q   <= '0;
        rdone_q <= 1'b0;
      end
      if (cap) begin
        gath_q <= iCORE_DATA;
        gvld_q <= 1'b1;
        bsel_q <= '0;
      end else if (beat) begin
        bsel_q <= bsel_q + 1'b1;
        if (glast) gvld_q <= 1'b0;
      end
      if (beat) ocnt_q <= ocnt_q + 1'b1;
    end
  end

  assign oS_READY      = rdy_q;
  assign oM_VALID      = gvld_q;
  assign oM_DATA       = gath_q[int'(bsel_q)*D_BIT +: D_BIT];
  assign oM_LAST       = gvld_q && (ocnt_q == C_BIT'(N_PT - 1));
  assign oCORE_WE      = we_q;
  assign oCORE_DATA    = wdat_q;
  assign oCORE_ADDR_WR = waddr_q;
  assign oCORE_ADDR_RD = {N_BANK{raddr_q}};
  assign oCORE_START   = (state_q == S_START);
  assign oBUSY         = (state_q != S_IDLE);

endmodule

// File: tb/tb_fht_stream_io.sv
// Directed bench for fht_stream_io: a 16-point, 4-bank two's complement instance backed by a RAM
// model, and an offset-binary continuous-frame instance backed by a 4a+k read model.
module tb_fht_stream_io;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  logic        s_valid, s_ready, m_valid, m_last, m_ready, core_start, core_rdy, busy;
  logic [14:0] s_data, core_data;
  logic [15:0] m_data;
  logic [3:0]  core_we;
  logic [1:0]  addr_wr;
  logic [7:0]  addr_rd;
  logic [63:0] core_rdata;

  logic        s_valid2, s_ready2, m_valid2, m_last2, m_ready2, core_start2, core_rdy2, busy2;
  logic [14:0] s_data2, core_data2;
  logic [15:0] m_data2;
  logic [3:0]  core_we2;
  logic [1:0]  addr_wr2;
  logic [7:0]  addr_rd2;
  logic [63:0] core_rdata2;

  fht_stream_io #(.N_PT(16), .N_BANK(4), .A_BIT(2), .IN_BIT(15), .D_BIT(16),
                  .SIGNED_IN(1), .RD_LAT(1), .CONT(0)) u_dut (
    .iCLK(clk), .iRESET(rst_n), .iS_VALID(s_valid), .iS_DATA(s_data), .oS_READY(s_ready),
    .oM_VALID(m_valid), .oM_DATA(m_data), .oM_LAST(m_last), .iM_READY(m_ready),
    .oCORE_WE(core_we), .oCORE_DATA(core_data), .oCORE_ADDR_WR(addr_wr),
    .oCORE_ADDR_RD(addr_rd), .iCORE_DATA(core_rdata), .oCORE_START(core_start),
    .iCORE_RDY(core_rdy), .oBUSY(busy));

  fht_stream_io #(.N_PT(16), .N_BANK(4), .A_BIT(2), .IN_BIT(15), .D_BIT(16),
                  .SIGNED_IN(0), .RD_LAT(1), .CONT(1)) u_dut2 (
    .iCLK(clk), .iRESET(rst_n), .iS_VALID(s_valid2), .iS_DATA(s_data2), .oS_READY(s_ready2),
    .oM_VALID(m_valid2), .oM_DATA(m_data2), .oM_LAST(m_last2), .iM_READY(m_ready2),
    .oCORE_WE(core_we2), .oCORE_DATA(core_data2), .oCORE_ADDR_WR(addr_wr2),
    .oCORE_ADDR_RD(addr_rd2), .iCORE_DATA(core_rdata2), .oCORE_START(core_start2),
    .iCORE_RDY(core_rdy2), .oBUSY(busy2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core stand-ins: banked RAM with one cycle read latency, and a fixed 4a+k read pattern.
  logic [15:0] mem [4][4];
  logic [15:0] rq  [4];
  logic [15:0] rq2 [4];
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (core_we[k]) mem[k][addr_wr] <= {core_data[14], core_data};
      rq[k]  <= mem[k][addr_rd[k*2 +: 2]];
      rq2[k] <= 16'(4 * int'(addr_rd2[k*2 +: 2]) + k);
    end
  end
  assign core_rdata  = {rq[3], rq[2], rq[1], rq[0]};
  assign core_rdata2 = {rq2[3], rq2[2], rq2[1], rq2[0]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send1(input logic [14:0] d, input int n, input bit verify);
    int t;
    logic [3:0] ewe;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("s_ready_timeout", 32'(t), 32'(0));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    if (verify) begin
      ewe = 4'b0001 << (n % 4);
      check("we", 32'(core_we), 32'(ewe));
      check("addr_wr", 32'(addr_wr), 32'(n / 4));
      check("core_data", 32'({core_data[14], core_data}), 32'({d[14], d}));
    end
  endtask

  task automatic send2(input logic [14:0] d);
    int t;
    t = 0;
    s_valid2 = 1'b1;
    s_data2  = d;
    @(negedge clk);
    while (!s_ready2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("s_ready2_timeout", 32'(t), 32'(0));
    @(posedge clk);
    #1;
    s_valid2 = 1'b0;
  endtask

  task automatic collect1(input bit rnd, input int base);
    int idx, t, first, lastc;
    logic pv, pr;
    logic [15:0] pd;
    idx = 0; t = 0; first = -1; lastc = 0; pv = 1'b0; pr = 1'b0; pd = '0;
    while (idx < 16 && t < 2000) begin
      @(posedge clk);
      #1;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      t++;
      if (pv && !pr) check("hold", 32'({m_valid, m_data}), 32'({1'b1, pd}));
      if (m_valid && m_ready) begin
        check("m_data", 32'(m_data), 32'(base + idx));
        check("m_last", 32'(m_last), 32'(idx == 15));
        if (first < 0) first = cyc;
        lastc = cyc;
        idx++;
      end
      pv = m_valid;
      pr = m_ready;
      pd = m_data;
    end
    if (t >= 2000) check("unload_timeout", 32'(idx), 32'(16));
    if (!rnd) check("b2b_span", 32'(lastc - first), 32'(15));
    @(posedge clk);
    #1;
    m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, t;
    rst_n = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0; core_rdy = 1'b0;
    s_valid2 = 1'b0; s_data2 = '0; m_ready2 = 1'b0; core_rdy2 = 1'b0;
    #12;
    check("rst_ready", 32'(s_ready), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_we", 32'(core_we), 32'(0));
    check("rst_start", 32'(core_start), 32'(0));
    check("rst_mvalid", 32'(m_valid), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_ready", 32'(s_ready), 32'(1));
    check("idle_busy", 32'(busy), 32'(0));

    // Frame 1: scatter pattern, start strobe, ignored input while running, full-rate unload.
    for (int n = 0; n < 16; n++) send1(15'(n), n, 1'b1);
    check("start_pulse", 32'(core_start), 32'(1));
    @(posedge clk);
    #1;
    check("start_one_cycle", 32'(core_start), 32'(0));
    check("run_busy", 32'(busy), 32'(1));
    s_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("run_no_ready", 32'(s_ready), 32'(0));
      check("run_no_we", 32'(core_we), 32'(0));
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    core_rdy = 1'b1;
    collect1(1'b0, 0);
    core_rdy = 1'b0;
    check("end_idle_busy", 32'(busy), 32'(0));
    check("end_mvalid", 32'(m_valid), 32'(0));

    // Frame 2: random downstream backpressure.
    for (int n = 0; n < 16; n++) send1(15'(100 + n), n, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    core_rdy = 1'b1;
    collect1(1'b1, 100);
    core_rdy = 1'b0;

    // Frame 3: done level already high at start must not trigger the unload.
    core_rdy = 1'b1;
    for (int n = 0; n < 16; n++) send1(15'(200 + n), n, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    core_rdy = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("stale_rdy_mvalid", 32'(m_valid), 32'(0));
    check("stale_rdy_busy", 32'(busy), 32'(1));
    core_rdy = 1'b1;
    collect1(1'b0, 200);
    core_rdy = 1'b0;

    // Offset-binary, continuous-frame instance.
    send2(15'h0000);
    check("ob_min", 32'({core_data2[14], core_data2}), 32'(16'hC000));
    check("ob_we0", 32'(core_we2), 32'(1));
    send2(15'h7FFF);
    check("ob_max", 32'({core_data2[14], core_data2}), 32'(16'h3FFF));
    check("ob_we1", 32'(core_we2), 32'(2));
    for (int n = 2; n < 16; n++) send2(15'(n));
    check("start2", 32'(core_start2), 32'(1));
    repeat (4) @(posedge clk);
    #1;
    core_rdy2 = 1'b1;
    m_ready2 = 1'b1;
    idx = 0; t = 0;
    while (idx < 16 && t < 2000) begin
      @(negedge clk);
      t++;
      if (m_valid2) begin
        check("m_data2", 32'(m_data2), 32'(idx));
        check("m_last2", 32'(m_last2), 32'(idx == 15));
        idx++;
      end
    end
    if (t >= 2000) check("unload2_timeout", 32'(idx), 32'(16));
    @(posedge clk);
    #1;
    m_ready2 = 1'b0;
    core_rdy2 = 1'b0;
    check("cont_busy", 32'(busy2), 32'(1));
    check("cont_ready", 32'(s_ready2), 32'(1));
    send2(15'h0005);
    check("cont_addr", 32'(addr_wr2), 32'(0));
    check("cont_we", 32'(core_we2), 32'(1));
    check("cont_data", 32'(core_data2), 32'(15'h4005));

    // Asynchronous reset in the middle of loading.
    for (int n = 0; n < 7; n++) send1(15'(n), n, 1'b0);
    s_valid = 1'b1;
    s_data = 15'd7;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    s_valid = 1'b0;
    check("mid_rst_we", 32'(core_we), 32'(0));
    check("mid_rst_data", 32'(core_data), 32'(0));
    check("mid_rst_addr", 32'(addr_wr), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_ready", 32'(s_ready), 32'(0));
    check("mid_rst_start", 32'(core_start), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("post_rst_start", 32'(core_start), 32'(0));
    end
    check("post_rst_busy", 32'(busy), 32'(0));
    send1(15'h4000, 0, 1'b1);
    check("signed_ext", 32'({core_data[14], core_data}), 32'(16'hC000));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
